multiplier_scheduler: RTL

//  Shares one registered 32x32 signed multiplier (input regs A/B, output reg) between two requesters.

---
 rtl/multiplier_scheduler.sv | 86 ++++++++
 1 files changed

// File: rtl/multiplier_scheduler.sv
// multiplier_scheduler: round-robin sharing of one registered signed multiplier between two requesters
module multiplier_scheduler #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                req0Valid,
  output logic                req0Ready,
  input  logic [DATA_W-1:0]   req0A,
  input  logic [DATA_W-1:0]   req0B,
  input  logic                req1Valid,
  output logic                req1Ready,
  input  logic [DATA_W-1:0]   req1A,
  input  logic [DATA_W-1:0]   req1B,
  output logic                resp0Valid,
  input  logic                resp0Ready,
  output logic                resp1Valid,
  input  logic                resp1Ready,
  output logic [2*DATA_W-1:0] respProduct,
  output logic [DATA_W-1:0]   mulA,
  output logic [DATA_W-1:0]   mulB,
  output logic                mulEnableA,
  output logic                mulEnableB,
  output logic                mulEnableOut,
  output logic                mulResetA,
  output logic                mulResetB,
  output logic                mulResetOut,
  input  logic [2*DATA_W-1:0] mulProduct,
  output logic                busy,
  output logic [CNT_W-1:0]    opCount
);
  typedef enum logic [1:0] {IDLE, LOAD, CAPTURE, RESP} state_t;
  state_t state, nextState;
  logic owner, lastGrant;
  logic grant0, grant1, start, handshake;
  // Both valid: the requester that did not win last time gets the multiplier.
  assign grant0    = req0Valid && (!req1Valid || lastGrant);
  assign grant1    = req1Valid && (!req0Valid || !lastGrant);
  assign start     = state == IDLE && !flush && (grant0 || grant1);
  assign handshake = state == RESP && !flush && (owner ? resp1Ready : resp0Ready);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
      opCount   <= '0;
    end else begin
      state <= nextState;
      if (start) begin
        owner     <= grant1;
        lastGrant <= grant1;
      end
      if (handshake) opCount <= opCount + CNT_W'(1);
    end
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = start ? LOAD : IDLE;
      LOAD:    nextState = CAPTURE;
      CAPTURE: nextState = RESP;
      RESP:    nextState = handshake ? IDLE : RESP;
      default: nextState = IDLE;
    endcase
    if (flush) nextState = IDLE;
  end
  // Combinational outputs are additionally gated by reset so they drop the moment reset asserts.
  always_comb begin
    req0Ready    = reset && start && grant0;
    req1Ready    = reset && start && grant1;
    mulA         = grant1 ? req1A : req0A;
    mulB         = grant1 ? req1B : req0B;
    mulEnableA   = reset && start;
    mulEnableB   = reset && start;
    mulEnableOut = reset && !flush && state == LOAD;
    mulResetA    = !reset || flush;
    mulResetB    = !reset || flush;
    mulResetOut  = !reset || flush;
    resp0Valid   = reset && !flush && state == RESP && !owner;
    resp1Valid   = reset && !flush && state == RESP && owner;
    respProduct  = (reset && (state == CAPTURE || state == RESP)) ? mulProduct : '0;
    busy         = state != IDLE;
  end
endmodule
